// File: rtl/multicycle_cpu_if.sv
// Fetch and data-memory bus between the multicycle core and its memories.
// The core drives the master side; instruction and data memories sit on the slave side.
interface multicycle_cpu_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [31:0]           pc;
  logic                  instr_read;
  logic [31:0]           instruction;
  logic                  instr_busywait;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_writedata;
  logic [DATA_WIDTH-1:0] mem_readdata;
  logic                  mem_busywait;

  modport master (
    output pc, instr_read, mem_read, mem_write, mem_address, mem_writedata,
    input  instruction, instr_busywait, mem_readdata, mem_busywait
  );

  modport slave (
    input  pc, instr_read, mem_read, mem_write, mem_address, mem_writedata,
    output instruction, instr_busywait, mem_readdata, mem_busywait
  );
endinterface

// File: rtl/multicycle_cpu.sv
// Multi-cycle CPU core: FETCH -> EXEC -> (MEM) -> FETCH with busywait handshakes on
// both memories, parametrised data width, register count and data address width.
module multicycle_cpu #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned REG_COUNT  = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  multicycle_cpu_if.master   bus,
  output logic               illegal
);

  localparam int unsigned RegIdxW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  localparam logic [7:0] OpLoadi = 8'd0;
  localparam logic [7:0] OpMov   = 8'd1;
  localparam logic [7:0] OpAdd   = 8'd2;
  localparam logic [7:0] OpSub   = 8'd3;
  localparam logic [7:0] OpAnd   = 8'd4;
  localparam logic [7:0] OpOr    = 8'd5;
  localparam logic [7:0] OpJ     = 8'd6;
  localparam logic [7:0] OpBeq   = 8'd7;
  localparam logic [7:0] OpBne   = 8'd8;
  localparam logic [7:0] OpLwd   = 8'd9;
  localparam logic [7:0] OpLwi   = 8'd10;
  localparam logic [7:0] OpSwd   = 8'd11;
  localparam logic [7:0] OpSwi   = 8'd12;

  // StBoot keeps every request low for the cycle after reset release.
  typedef enum logic [1:0] {StBoot, StFetch, StExec, StMem} state_e;

  state_e                state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic [31:0]           ir_q, ir_d;
  logic                  illegal_q, illegal_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rf_q [REG_COUNT];

  logic                  rf_we;
  logic [RegIdxW-1:0]    rf_wa;
  logic [DATA_WIDTH-1:0] rf_wd;

  logic [7:0]            opcode;
  logic [RegIdxW-1:0]    rd, rs1, rs2;
  logic [DATA_WIDTH-1:0] op_a, op_b, imm_ext;
  logic [31:0]           pc_plus4, br_target;
  logic                  is_store;
  logic                  unused_ir;

  assign opcode    = ir_q[31:24];
  assign rd        = ir_q[16 +: RegIdxW];
  assign rs1       = ir_q[8 +: RegIdxW];
  assign rs2       = ir_q[0 +: RegIdxW];
  assign op_a      = rf_q[rs1];
  assign op_b      = rf_q[rs2];
  assign imm_ext   = DATA_WIDTH'($signed(ir_q[7:0]));
  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {{22{ir_q[23]}}, ir_q[23:16], 2'b00};
  assign is_store  = (opcode == OpSwd) || (opcode == OpSwi);
  assign unused_ir = ^ir_q[15:8];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rf_we     = 1'b0;
    rf_wa     = rd;
    rf_wd     = '0;
    unique case (state_q)
      StBoot: state_d = StFetch;
      StFetch: begin
        if (!bus.instr_busywait) begin
          ir_d    = bus.instruction;
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StFetch;
        pc_d    = pc_plus4;
        case (opcode)
          OpLoadi: begin rf_we = 1'b1; rf_wd = imm_ext;       end
          OpMov:   begin rf_we = 1'b1; rf_wd = op_b;          end
          OpAdd:   begin rf_we = 1'b1; rf_wd = op_a + op_b;   end
          OpSub:   begin rf_we = 1'b1; rf_wd = op_a + ~op_b + DATA_WIDTH'(1); end
          OpAnd:   begin rf_we = 1'b1; rf_wd = op_a & op_b;   end
          OpOr:    begin rf_we = 1'b1; rf_wd = op_a | op_b;   end
          OpJ:     pc_d = br_target;
          OpBeq:   if (op_a == op_b) pc_d = br_target;
          OpBne:   if (op_a != op_b) pc_d = br_target;
          OpLwd, OpSwd: begin
            addr_d  = ADDR_WIDTH'(op_b);
            wdata_d = op_a;
            pc_d    = pc_q;
            state_d = StMem;
          end
          OpLwi, OpSwi: begin
            addr_d  = ADDR_WIDTH'(ir_q[7:0]);
            wdata_d = op_a;
            pc_d    = pc_q;
            state_d = StMem;
          end
          default: illegal_d = 1'b1;
        endcase
      end
      StMem: begin
        if (!bus.mem_busywait) begin
          if (!is_store) begin
            rf_we = 1'b1;
            rf_wd = bus.mem_readdata;
          end
          pc_d    = pc_plus4;
          state_d = StFetch;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StBoot;
      pc_q      <= '0;
      ir_q      <= '0;
      illegal_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rf_wa] <= rf_wd;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.instr_read    = (state_q == StFetch);
  assign bus.mem_read      = (state_q == StMem) && !is_store;
  assign bus.mem_write     = (state_q == StMem) && is_store;
  assign bus.mem_address   = addr_q;
  assign bus.mem_writedata = wdata_q;
  assign illegal           = illegal_q;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Bench for multicycle_cpu (16-bit data, 8 registers): directed programs plus random ones,
// all checked against an instruction-level model with latency derived from wait counts.
module tb_multicycle_cpu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic illegal;

  multicycle_cpu_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus ();

  multicycle_cpu #(.DATA_WIDTH(16), .REG_COUNT(8), .ADDR_WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Memory environment: programmable wait states, store log.
  logic [31:0] prog [logic [31:0]];
  logic [15:0] dwr [int];
  logic [23:0] act_st [$];
  int iwait = 0, dwait = 0, seed = 0, epoch = 0;
  int icnt = 0, dcnt = 0, wr_cycles = 0;

  function automatic logic [15:0] init_word(input int a);
    return 16'(a * 40503 + seed);
  endfunction

  always @(negedge clk) begin
    int key;
    logic busy;
    if (bus.instr_read) begin
      bus.instr_busywait = (icnt < iwait);
      bus.instruction = prog.exists(bus.pc) ? prog[bus.pc] : 32'h0;
      icnt++;
    end else begin
      icnt = 0;
      bus.instr_busywait = 1'b0;
    end
    if (bus.mem_read || bus.mem_write) begin
      key = epoch * 256 + int'(bus.mem_address);
      busy = (dcnt < dwait);
      bus.mem_busywait = busy;
      bus.mem_readdata = dwr.exists(key) ? dwr[key] : init_word(int'(bus.mem_address));
      dcnt++;
      if (bus.mem_write) begin
        wr_cycles++;
        if (!busy) begin
          dwr[key] = bus.mem_writedata;
          act_st.push_back({bus.mem_address, bus.mem_writedata});
        end
      end
    end else begin
      dcnt = 0;
      bus.mem_busywait = 1'b0;
    end
  end

  // Instruction-level reference model.
  logic [31:0] m_pc;
  logic [15:0] m_r [8];
  logic [15:0] m_mem [256];
  logic        m_ill;
  logic [23:0] exp_st [$];
  int          cyc;
  int          act_base;

  function automatic logic [31:0] word(input int op, input int d, input int s1, input int s2);
    return {8'(op), 8'(d), 8'(s1), 8'(s2)};
  endfunction

  function automatic logic [31:0] rand_word();
    int op;
    op = $urandom_range(0, 13);
    if (op == 13) op = $urandom_range(13, 255);
    return {8'(op), 24'($urandom)};
  endfunction

  task automatic model_run(input int n, input bit rnd);
    logic [31:0] w, nxt;
    logic [15:0] sx, a, b;
    logic [7:0]  ad;
    int d, s2, s1;
    m_pc = 0; m_ill = 0; cyc = 0;
    exp_st.delete();
    for (int i = 0; i < 8; i++) m_r[i] = 0;
    for (int i = 0; i < 256; i++) m_mem[i] = init_word(i);
    for (int k = 0; k < n; k++) begin
      if (!prog.exists(m_pc)) prog[m_pc] = rnd ? rand_word() : 32'h0;
      w = prog[m_pc];
      d = int'(w[23:16]) % 8; s1 = int'(w[15:8]) % 8; s2 = int'(w[7:0]) % 8;
      a = m_r[s1]; b = m_r[s2];
      sx = {{8{w[7]}}, w[7:0]};
      nxt = m_pc + 4;
      cyc += 2 + iwait;
      case (int'(w[31:24]))
        0: m_r[d] = sx;
        1: m_r[d] = b;
        2: m_r[d] = a + b;
        3: m_r[d] = a - b;
        4: m_r[d] = a & b;
        5: m_r[d] = a | b;
        6: nxt = nxt + 4 * {{24{w[23]}}, w[23:16]};
        7: if (a == b) nxt = nxt + 4 * {{24{w[23]}}, w[23:16]};
        8: if (a != b) nxt = nxt + 4 * {{24{w[23]}}, w[23:16]};
        9, 10, 11, 12: begin
          ad = (w[31:24] == 8'd9 || w[31:24] == 8'd11) ? b[7:0] : w[7:0];
          if (w[31:24] <= 8'd10) m_r[d] = m_mem[ad];
          else begin
            m_mem[ad] = a;
            exp_st.push_back({ad, a});
          end
          cyc += 1 + dwait;
        end
        default: m_ill = 1;
      endcase
      m_pc = nxt;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reset, release, then run 'cycles' clocks counted from the first fetch cycle.
  task automatic run_dut(input int cycles);
    rst_n = 1'b0;
    @(negedge clk);
    act_base = act_st.size();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string name);
    int n;
    chk({name, "_fetch"}, 32'(bus.instr_read), 32'd1);
    chk({name, "_pc"}, bus.pc, m_pc);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_r%0d", name, i), 32'(dut.rf_q[i]), 32'(m_r[i]));
    chk({name, "_illegal"}, 32'(illegal), 32'(m_ill));
    n = act_st.size() - act_base;
    chk({name, "_stores"}, 32'(n), 32'(exp_st.size()));
    for (int i = 0; i < n && i < exp_st.size(); i++)
      chk($sformatf("%s_st%0d", name, i), 32'(act_st[act_base + i]), 32'(exp_st[i]));
  endtask

  task automatic do_prog(input string name, input int n, input bit rnd);
    epoch++;
    seed = $urandom;
    model_run(n, rnd);
    run_dut(cyc);
    check_all(name);
  endtask

  initial begin
    int wsnap, ssnap;

    // ALU program, zero wait
    prog.delete(); iwait = 0; dwait = 0;
    prog[0] = word(0, 1, 0, 5); prog[4] = word(0, 2, 0, 3);
    prog[8] = word(3, 3, 1, 2); prog[12] = word(4, 4, 1, 2);
    do_prog("alu", 4, 0);
    chk("alu_r3", 32'(dut.rf_q[3]), 32'd2);
    chk("alu_r4", 32'(dut.rf_q[4]), 32'd1);
    chk("alu_pc8cyc", bus.pc, 32'd16);

    // sign extension and wrap at 16 bits
    prog.delete();
    prog[0] = word(0, 1, 0, 8'h80); prog[4] = word(2, 2, 1, 1);
    do_prog("sext", 2, 0);
    chk("sext_r1", 32'(dut.rf_q[1]), 32'hFF80);
    chk("sext_r2", 32'(dut.rf_q[2]), 32'hFF00);

    // branches
    prog.delete();
    prog[0] = word(0, 1, 0, 7); prog[4] = word(0, 2, 0, 7); prog[8] = word(7, 8'hFE, 1, 2);
    do_prog("beq_t", 3, 0);
    chk("beq_t_pc", bus.pc, 32'd4);
    prog[4] = word(0, 2, 0, 6);
    do_prog("beq_n", 3, 0);
    chk("beq_n_pc", bus.pc, 32'd12);
    prog[8] = word(8, 3, 1, 2);
    do_prog("bne_t", 3, 0);
    chk("bne_t_pc", bus.pc, 32'd24);
    prog.delete();
    prog[0] = word(6, 8'h80, 0, 0);
    do_prog("jwrap", 1, 0);
    chk("jwrap_pc", bus.pc, 32'hFFFFFE04);

    // store/load with 2-cycle data busywait
    prog.delete(); dwait = 2;
    prog[0] = word(0, 1, 0, 8'h5A); prog[4] = word(12, 0, 1, 8'h10); prog[8] = word(10, 5, 0, 8'h10);
    wsnap = wr_cycles;
    do_prog("mem", 3, 0);
    chk("mem_cycles", 32'(cyc), 32'd12);
    chk("mem_wr_held", 32'(wr_cycles - wsnap), 32'd3);
    chk("mem_st", 32'(act_st[act_base]), {8'h0, 8'h10, 16'h005A});
    chk("mem_r5", 32'(dut.rf_q[5]), 32'h5A);

    // reset in the middle of a stalled store
    prog.delete(); dwait = 1000; epoch++;
    prog[0] = word(0, 1, 0, 8'h33); prog[4] = word(12, 0, 1, 8'h20);
    run_dut(4);
    @(posedge clk); #1;
    chk("rst_pre_wr", 32'(bus.mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_iread", 32'(bus.instr_read), 32'd0);
    chk("rst_mread", 32'(bus.mem_read), 32'd0);
    chk("rst_mwrite", 32'(bus.mem_write), 32'd0);
    chk("rst_pc", bus.pc, 32'd0);
    chk("rst_addr", 32'(bus.mem_address), 32'd0);
    chk("rst_wdata", 32'(bus.mem_writedata), 32'd0);
    chk("rst_r1", 32'(dut.rf_q[1]), 32'd0);
    prog[4] = word(0, 2, 0, 1);
    dwait = 0;
    @(negedge clk);
    wsnap = wr_cycles; ssnap = act_st.size();
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_fetch", 32'(bus.instr_read), 32'd1);
    chk("rel_pc", bus.pc, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("rel_no_wr", 32'(wr_cycles - wsnap), 32'd0);
    chk("rel_no_st", 32'(act_st.size() - ssnap), 32'd0);
    chk("rel_r2", 32'(dut.rf_q[2]), 32'd1);

    // illegal opcode is a sticky NOP
    prog.delete();
    prog[0] = word(0, 1, 0, 9); prog[4] = word(8'hFF, 1, 1, 1); prog[8] = word(2, 2, 1, 1);
    do_prog("ill", 3, 0);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_r1", 32'(dut.rf_q[1]), 32'd9);
    rst_n = 1'b0;
    #1;
    chk("ill_clear", 32'(illegal), 32'd0);

    // random programs with random wait states
    for (int p = 0; p < 6; p++) begin
      prog.delete();
      iwait = $urandom_range(0, 2);
      dwait = $urandom_range(0, 2);
      do_prog($sformatf("rnd%0d", p), 40, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_cpu.md
Name: multicycle_cpu

Overview:
- Parametrised multi-cycle successor to the group's single-cycle 8-bit CPU core.
- Keeps the same 32-bit instruction encoding and base ISA (loadi, mov, add, sub, and, or, j, beq, bne).
- Adds load/store instructions, generic data width and register count, and busywait handshakes to instruction and data memories.
- Sits between an instruction memory/cache and a data memory/cache at the top level.

Parameters:
- DATA_WIDTH, 8, register/ALU/data-memory word width; 8..32.
- REG_COUNT, 8, number of general registers; power of two, 2..16.
- ADDR_WIDTH, 8, data-memory address width; 1..32.

Ports:
- CLK  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-low reset
- PC  out  32  address of the instruction being fetched or executed
- INSTR_READ  out  1  instruction-fetch request
- INSTRUCTION  in  32  instruction word; valid when INSTR_READ=1 and INSTR_BUSYWAIT=0
- INSTR_BUSYWAIT  in  1  instruction memory not ready
- MEM_READ  out  1  data read request
- MEM_WRITE  out  1  data write request
- MEM_ADDRESS  out  ADDR_WIDTH  data address
- MEM_WRITEDATA  out  DATA_WIDTH  store data
- MEM_READDATA  in  DATA_WIDTH  load data; valid on completion
- MEM_BUSYWAIT  in  1  data memory not ready
- ILLEGAL  out  1  sticky flag: an undefined opcode has been executed

Behaviour:
- Encoding:
  - OPCODE=[31:24]; DEST/OFFSET=[23:16]; SRC1=[15:8]; SRC2/IMM=[7:0].
  - Register index = low log2(REG_COUNT) bits of each field.
- Opcodes:
  - 0 loadi: R[d]=sext(IMM).
  - 1 mov: R[d]=R[s2].
  - 2 add, 3 sub, 4 and, 5 or: R[d]=R[s1] op R[s2].
  - 6 j.
  - 7 beq: taken if R[s1]==R[s2].
  - 8 bne: taken if R[s1]!=R[s2].
  - 9 lwd: R[d]=M[R[s2]].
  - 10 lwi: R[d]=M[IMM].
  - 11 swd: M[R[s2]]=R[s1].
  - 12 swi: M[IMM]=R[s1].
  - All other opcodes: NOP that sets ILLEGAL.
- Arithmetic:
  - All ALU results are modulo 2^DATA_WIDTH; sub is R[s1]+(~R[s2])+1.
  - IMM is sign-extended to DATA_WIDTH.
  - Memory address = low ADDR_WIDTH bits of R[s2] or IMM, zero-extended if ADDR_WIDTH>8 (IMM) or >DATA_WIDTH (register).
- PC:
  - Fall-through next PC = PC+4.
  - Taken j/beq/bne: PC+4 + (sext32(OFFSET)<<2), wrapping mod 2^32.
- FSM: FETCH -> EXEC -> (MEM) -> FETCH.
  - FETCH: INSTR_READ=1. On the first rising edge with INSTR_BUSYWAIT=0, latch INSTRUCTION into the IR and go to EXEC.
  - EXEC, ALU/branch/illegal: on this edge write R[d] (ALU ops only), update PC, go to FETCH.
  - EXEC, lwd/lwi/swd/swi: latch address and store data, go to MEM; PC unchanged.
  - MEM: MEM_READ or MEM_WRITE held at 1 with address/data stable. On the first edge with MEM_BUSYWAIT=0:
    - load: write MEM_READDATA to R[d];
    - both: PC=PC+4, drop the request, go to FETCH.
- Latency with zero-wait memories: ALU/branch = 2 cycles; load/store = 3 cycles; each busywait cycle adds 1.
- MEM_READ and MEM_WRITE are never asserted together. INSTR_READ is never asserted together with either.
- Requests are Moore outputs decoded from state only.
- Register file: two combinational reads, one synchronous write per instruction.
  - A register used as both source and destination reads its old value.
  - Write-to-R0 is a normal write.
- Reset (RESET=0, any state, including mid-MEM or mid-FETCH):
  - immediately: PC=0, all registers=0, ILLEGAL=0, state=FETCH;
  - INSTR_READ, MEM_READ, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0;
  - an aborted store must not be re-issued after reset.
- Release: first fetch begins on the first rising edge after RESET returns high; INSTR_READ=1 from that cycle.
- Busywait held high indefinitely: the core stalls in the current state with outputs stable; no timeout.

Test Plan:
- Zero-wait memories, program: loadi r1,5; loadi r2,3; sub r3,r1,r2; and r4,r1,r2.
  -> r3=2, r4=1, PC=16 after 8 cycles.
- DATA_WIDTH=16: loadi r1,0x80; add r2,r1,r1.
  -> r1=0xFF80, r2=0xFF00 (sign-extension and wrap).
- Branches: r1=r2=7; beq offset=-2 at PC=8 -> PC=4. With r1!=r2: beq -> PC=12, bne offset=+3 -> PC=24. j offset=0x80 at PC=0 -> PC=0xFFFFFE04.
- Memory with 2-cycle busywait: swi r1(=0x5A),0x10; lwi r5,0x10.
  -> MEM_WRITE held 3 cycles at MEM_ADDRESS=0x10, MEM_WRITEDATA=0x5A; r5=0x5A; each instruction takes 5 cycles.
- Reset asserted mid-MEM while MEM_BUSYWAIT=1.
  -> all requests drop within the same cycle, PC=0, registers=0. After release: fetch at PC=0, no stray MEM_WRITE.
- Opcode 0xFF -> ILLEGAL=1 and stays 1, registers unchanged, PC advances by 4; a subsequent reset clears ILLEGAL.
